// File: rtl/crforth_pkg.sv
// Shared definitions for the Forth core: data widths, stack depth limits and
// the stack operation encoding used by the control sequencer.
package crforth_pkg;

   localparam int unsigned WIDTH     = 16;
   localparam int unsigned RAM_DEPTH = 14;
   localparam int unsigned MAXD      = RAM_DEPTH + 2;
   localparam int unsigned DW        = $clog2(MAXD + 1);
   localparam int unsigned AW        = $clog2(RAM_DEPTH);

   typedef enum logic [2:0] {
      STK_NOP   = 3'b000,
      STK_PUSH  = 3'b001,
      STK_DROP  = 3'b010,
      STK_BINOP = 3'b011,
      STK_UNOP  = 3'b100,
      STK_DUP   = 3'b101,
      STK_SWAP  = 3'b110,
      STK_OVER  = 3'b111
   } stack_op_e;

   // Minimum depth an op needs, and whether it adds or removes one entry.
   typedef struct packed {
      logic [1:0] need;
      logic       grow;
      logic       shrink;
   } op_info_t;

   function automatic op_info_t op_info(input stack_op_e op);
      op_info_t info;
      info = '0;
      case (op)
         STK_PUSH:  info = '{need: 2'd0, grow: 1'b1, shrink: 1'b0};
         STK_DROP:  info = '{need: 2'd1, grow: 1'b0, shrink: 1'b1};
         STK_BINOP: info = '{need: 2'd2, grow: 1'b0, shrink: 1'b1};
         STK_UNOP:  info = '{need: 2'd1, grow: 1'b0, shrink: 1'b0};
         STK_DUP:   info = '{need: 2'd1, grow: 1'b1, shrink: 1'b0};
         STK_SWAP:  info = '{need: 2'd2, grow: 1'b0, shrink: 1'b0};
         STK_OVER:  info = '{need: 2'd2, grow: 1'b1, shrink: 1'b0};
         default:   info = '0;
      endcase
      return info;
   endfunction

endpackage

// File: rtl/stack_ram.sv
// Backing store for stack entries below NOS: synchronous write, asynchronous read.
module stack_ram
   import crforth_pkg::*;
(
   input  logic             c_YCLOCK,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [RAM_DEPTH];

   always_ff @(posedge c_YCLOCK) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/data_stack.sv
// Forth parameter stack: TOS/NOS in registers feeding the ALU, deeper entries
// spilled to stack_ram. One op per clock; rejected ops only set sticky flags.
module data_stack
   import crforth_pkg::*;
(
   input  logic             c_YCLOCK,
   input  logic             c_RESET,
   input  logic [2:0]       f_stackctrl,
   input  logic [WIDTH-1:0] i_DATA,
   output logic [WIDTH-1:0] o_TOS,
   output logic [WIDTH-1:0] o_NOS,
   output logic [DW-1:0]    o_DEPTH,
   output logic             o_EMPTY,
   output logic             o_FULL,
   output logic             o_UFLOW,
   output logic             o_OFLOW
);

   stack_op_e        op;
   op_info_t         info;
   logic             deep2;
   logic             deep3;
   logic [WIDTH-1:0] below;
   logic [WIDTH-1:0] push_val;

   logic [WIDTH-1:0] tos_n;
   logic [WIDTH-1:0] nos_n;
   logic [DW-1:0]    depth_n;
   logic             uflow_n;
   logic             oflow_n;

   logic             ram_we;
   logic [AW-1:0]    ram_waddr;
   logic [AW-1:0]    ram_raddr;
   logic [WIDTH-1:0] ram_rdata;

   stack_ram u_ram (
      .c_YCLOCK (c_YCLOCK),
      .we       (ram_we),
      .waddr    (ram_waddr),
      .wdata    (o_NOS),
      .raddr    (ram_raddr),
      .rdata    (ram_rdata)
   );

   assign o_EMPTY = (o_DEPTH == '0);
   assign o_FULL  = (o_DEPTH == DW'(MAXD));

   // Op decode, need/grow checks and next-state selection.
   always_comb begin
      op        = stack_op_e'(f_stackctrl);
      info      = op_info(op);
      deep2     = (o_DEPTH >= DW'(2));
      deep3     = (o_DEPTH >= DW'(3));
      ram_raddr = deep3 ? AW'(o_DEPTH - DW'(3)) : '0;
      ram_waddr = deep2 ? AW'(o_DEPTH - DW'(2)) : '0;
      below     = deep3 ? ram_rdata : '0;

      tos_n   = o_TOS;
      nos_n   = o_NOS;
      depth_n = o_DEPTH;
      uflow_n = o_UFLOW;
      oflow_n = o_OFLOW;
      ram_we  = 1'b0;

      case (op)
         STK_PUSH: push_val = i_DATA;
         STK_DUP:  push_val = o_TOS;
         default:  push_val = o_NOS;
      endcase

      if (o_DEPTH < DW'(info.need)) begin
         uflow_n = 1'b1;
      end else if (info.grow && o_FULL) begin
         oflow_n = 1'b1;
      end else begin
         case (op)
            STK_PUSH, STK_DUP, STK_OVER: begin
               ram_we = deep2;
               nos_n  = o_TOS;
               tos_n  = push_val;
            end
            STK_DROP: begin
               tos_n = o_NOS;
               nos_n = below;
            end
            STK_BINOP: begin
               tos_n = i_DATA;
               nos_n = below;
            end
            STK_UNOP: begin
               tos_n = i_DATA;
            end
            STK_SWAP: begin
               tos_n = o_NOS;
               nos_n = o_TOS;
            end
            default: ;
         endcase
         if (info.grow) begin
            depth_n = o_DEPTH + DW'(1);
         end else if (info.shrink) begin
            depth_n = o_DEPTH - DW'(1);
         end
      end
   end

   always_ff @(posedge c_YCLOCK) begin
      if (c_RESET) begin
         o_TOS   <= '0;
         o_NOS   <= '0;
         o_DEPTH <= '0;
         o_UFLOW <= 1'b0;
         o_OFLOW <= 1'b0;
      end else begin
         o_TOS   <= tos_n;
         o_NOS   <= nos_n;
         o_DEPTH <= depth_n;
         o_UFLOW <= uflow_n;
         o_OFLOW <= oflow_n;
      end
   end

endmodule

// File: tb/tb_data_stack.sv
// Self-checking bench for data_stack: directed vector table, hand sequences
// and random ops against a queue-based stack model.
module tb_data_stack;
   import crforth_pkg::*;

   logic             c_YCLOCK = 1'b0;
   logic             c_RESET;
   logic [2:0]       f_stackctrl;
   logic [WIDTH-1:0] i_DATA;
   logic [WIDTH-1:0] o_TOS;
   logic [WIDTH-1:0] o_NOS;
   logic [DW-1:0]    o_DEPTH;
   logic             o_EMPTY;
   logic             o_FULL;
   logic             o_UFLOW;
   logic             o_OFLOW;

   int checks = 0;
   int errors = 0;

   always #5 c_YCLOCK = ~c_YCLOCK;

   data_stack dut (
      .c_YCLOCK    (c_YCLOCK),
      .c_RESET     (c_RESET),
      .f_stackctrl (f_stackctrl),
      .i_DATA      (i_DATA),
      .o_TOS       (o_TOS),
      .o_NOS       (o_NOS),
      .o_DEPTH     (o_DEPTH),
      .o_EMPTY     (o_EMPTY),
      .o_FULL      (o_FULL),
      .o_UFLOW     (o_UFLOW),
      .o_OFLOW     (o_OFLOW)
   );

   localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, DROP = 3'd2, BINOP = 3'd3,
                          UNOP = 3'd4, DUP = 3'd5, SWAP = 3'd6, OVER = 3'd7;

   typedef struct {
      logic        rst;
      logic [2:0]  op;
      logic [15:0] data;
      logic [15:0] tos;
      logic [15:0] nos;
      int          depth;
      logic        uflow;
      logic        oflow;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic [15:0] tos, input logic [15:0] nos,
                            input int depth, input logic uf, input logic of);
      chk({tag, " tos"},   int'(o_TOS), int'(tos));
      chk({tag, " nos"},   int'(o_NOS), int'(nos));
      chk({tag, " depth"}, int'(o_DEPTH), depth);
      chk({tag, " empty"}, int'(o_EMPTY), int'(depth == 0));
      chk({tag, " full"},  int'(o_FULL), int'(depth == int'(MAXD)));
      chk({tag, " uflow"}, int'(o_UFLOW), int'(uf));
      chk({tag, " oflow"}, int'(o_OFLOW), int'(of));
   endtask

   // Drive one op for one clock; outputs are settled #1 after the edge.
   task automatic step(input logic rst, input logic [2:0] op, input logic [15:0] data);
      @(negedge c_YCLOCK);
      c_RESET     = rst;
      f_stackctrl = op;
      i_DATA      = data;
      @(posedge c_YCLOCK);
      #1;
   endtask

   // Reference model: unbounded queue with capacity and need rules applied on top.
   logic [15:0] mq[$];
   logic        m_uf, m_of;

   function automatic int need_of(input logic [2:0] op);
      case (op)
         DROP, UNOP, DUP:   return 1;
         BINOP, SWAP, OVER: return 2;
         default:           return 0;
      endcase
   endfunction

   task automatic model_op(input logic rst, input logic [2:0] op, input logic [15:0] data);
      logic [15:0] a, b;
      if (rst) begin
         mq.delete();
         m_uf = 1'b0;
         m_of = 1'b0;
         return;
      end
      if (mq.size() < need_of(op)) begin
         m_uf = 1'b1;
         return;
      end
      if ((op == PUSH || op == DUP || op == OVER) && mq.size() == int'(MAXD)) begin
         m_of = 1'b1;
         return;
      end
      case (op)
         PUSH:  mq.push_back(data);
         DUP:   mq.push_back(mq[$]);
         OVER:  mq.push_back(mq[$-1]);
         DROP:  void'(mq.pop_back());
         BINOP: begin void'(mq.pop_back()); void'(mq.pop_back()); mq.push_back(data); end
         UNOP:  begin void'(mq.pop_back()); mq.push_back(data); end
         SWAP:  begin a = mq.pop_back(); b = mq.pop_back(); mq.push_back(a); mq.push_back(b); end
         default: ;
      endcase
   endtask

   task automatic model_check(input string tag);
      logic [15:0] t, n;
      t = (mq.size() > 0) ? mq[$] : 16'h0;
      n = (mq.size() > 1) ? mq[$-1] : 16'h0;
      check_all(tag, t, n, mq.size(), m_uf, m_of);
   endtask

   vec_t vecs[$];

   initial begin
      c_RESET     = 1'b1;
      f_stackctrl = NOP;
      i_DATA      = '0;

      vecs = '{
         '{1'b1, NOP,   16'd0,     16'd0,     16'd0, 0, 1'b0, 1'b0},
         '{1'b0, PUSH,  16'd5,     16'd5,     16'd0, 1, 1'b0, 1'b0},
         '{1'b0, PUSH,  16'd7,     16'd7,     16'd5, 2, 1'b0, 1'b0},
         '{1'b0, BINOP, 16'd12,    16'd12,    16'd0, 1, 1'b0, 1'b0},
         '{1'b0, DROP,  16'd0,     16'd0,     16'd0, 0, 1'b0, 1'b0},
         '{1'b0, DROP,  16'd0,     16'd0,     16'd0, 0, 1'b1, 1'b0},
         '{1'b1, NOP,   16'd0,     16'd0,     16'd0, 0, 1'b0, 1'b0},
         '{1'b0, PUSH,  16'd3,     16'd3,     16'd0, 1, 1'b0, 1'b0},
         '{1'b0, SWAP,  16'd0,     16'd3,     16'd0, 1, 1'b1, 1'b0},
         '{1'b1, NOP,   16'd0,     16'd0,     16'd0, 0, 1'b0, 1'b0},
         '{1'b0, PUSH,  16'hFFFD,  16'hFFFD,  16'd0, 1, 1'b0, 1'b0},
         '{1'b0, UNOP,  16'd3,     16'd3,     16'd0, 1, 1'b0, 1'b0},
         '{1'b0, PUSH,  16'd1,     16'd1,     16'd3, 2, 1'b0, 1'b0},
         '{1'b0, PUSH,  16'd2,     16'd2,     16'd1, 3, 1'b0, 1'b0},
         '{1'b0, PUSH,  16'd3,     16'd3,     16'd2, 4, 1'b0, 1'b0},
         '{1'b0, PUSH,  16'd4,     16'd4,     16'd3, 5, 1'b0, 1'b0},
         '{1'b1, PUSH,  16'd9,     16'd0,     16'd0, 0, 1'b0, 1'b0},
         '{1'b0, NOP,   16'd0,     16'd0,     16'd0, 0, 1'b0, 1'b0}
      };
      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].op, vecs[i].data);
         check_all($sformatf("vec%0d", i), vecs[i].tos, vecs[i].nos, vecs[i].depth,
                   vecs[i].uflow, vecs[i].oflow);
      end

      // Fill to capacity, overflow, then drain through the RAM.
      step(1'b1, NOP, 16'd0);
      for (int i = 1; i <= int'(MAXD); i++) step(1'b0, PUSH, 16'(i));
      check_all("full", 16'd16, 16'd15, 16, 1'b0, 1'b0);
      step(1'b0, PUSH, 16'd99);
      check_all("oflow", 16'd16, 16'd15, 16, 1'b0, 1'b1);
      step(1'b0, DUP, 16'd0);
      check_all("oflow_dup", 16'd16, 16'd15, 16, 1'b0, 1'b1);
      for (int i = 0; i < 14; i++) step(1'b0, DROP, 16'd0);
      check_all("drain14", 16'd2, 16'd1, 2, 1'b0, 1'b1);
      step(1'b0, DROP, 16'd0);
      check_all("drain15", 16'd1, 16'd0, 1, 1'b0, 1'b1);

      // SWAP / OVER / DUP reordering across the register/RAM boundary.
      step(1'b1, NOP, 16'd0);
      step(1'b0, PUSH, 16'd10);
      step(1'b0, PUSH, 16'd20);
      step(1'b0, PUSH, 16'd30);
      step(1'b0, SWAP, 16'd0);
      check_all("swap", 16'd20, 16'd30, 3, 1'b0, 1'b0);
      step(1'b0, OVER, 16'd0);
      check_all("over", 16'd30, 16'd20, 4, 1'b0, 1'b0);
      step(1'b0, DUP, 16'd0);
      check_all("dup", 16'd30, 16'd30, 5, 1'b0, 1'b0);
      step(1'b0, DROP, 16'd0);
      step(1'b0, DROP, 16'd0);
      check_all("drop2", 16'd20, 16'd30, 3, 1'b0, 1'b0);
      step(1'b0, DROP, 16'd0);
      check_all("drop3", 16'd30, 16'd10, 2, 1'b0, 1'b0);
      step(1'b0, DROP, 16'd0);
      check_all("drop4", 16'd10, 16'd0, 1, 1'b0, 1'b0);

      // Random ops against the queue model, with occasional resets.
      step(1'b1, NOP, 16'd0);
      model_op(1'b1, NOP, 16'd0);
      for (int i = 0; i < 3000; i++) begin
         logic        r;
         logic [2:0]  op;
         logic [15:0] d;
         r  = ($urandom_range(0, 199) == 0);
         op = (i % 400 < 200) ? (($urandom_range(0, 2) == 0) ? 3'($urandom_range(2, 7)) : PUSH)
                              : 3'($urandom_range(0, 7));
         d  = 16'($urandom);
         step(r, op, d);
         model_op(r, op, d);
         model_check($sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
